pc_ctl: RTL and testbench
=========================

# pc_ctl

Run controller and branch-target generator that drives the program counter's control inputs (Start, Done, Branch, target). It accepts a run request, pins the counter at 0 until launch, and resolves taken branches through a writable target table. It stops the run on a halt opcode or counter overrun and reports completion with a one-cycle acknowledge and a cycle count. It sits between the instruction decoder/flags and the program counter.

## Interface
- D, 12, program counter / target width
- LUT_AW, 3, target-table index width (2**LUT_AW entries)
- CW, 16, run cycle counter width

- clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Req  in  1  run request, sampled only in IDLE
- Ack  out  1  one-cycle pulse at run completion
- Err  out  1  sticky overrun flag; cleared on accepted Req
- Cycles  out  CW  RUN cycles of the current/last run, saturating
- prog_ctr  in  D  current program counter value
- Halt_op  in  1  decoded current instruction is halt
- Br_op  in  1  decoded current instruction is a conditional branch
- Br_cond  in  1  branch condition flag
- Lut_idx  in  LUT_AW  target-table read index for the current instruction
- Lut_we  in  1  target-table write enable
- Lut_waddr  in  LUT_AW  write index
- Lut_wdata  in  D  write data
- Start  out  1  to counter: synchronous clear
- Done  out  1  to counter: hold
- Branch  out  1  to counter: load target
- target  out  D  to counter: absolute jump address

## Operation
- States: IDLE, RUN, HALT.
- IDLE: Start=1, Done=1, Branch=0. Req=1 -> RUN; Cycles cleared to 0, Err cleared. The counter is cleared at that same edge, so first RUN cycle sees prog_ctr=0.
- RUN: Start=0. Done=0 unless stopping. Outputs are combinational from current-cycle decoder inputs:
  - target = lut[Lut_idx] always (also in IDLE/HALT).
  - Branch = Br_op & Br_cond & (lut[Lut_idx] != 0) & ~Halt_op. A zero table entry means "not taken" (the counter treats target 0 as increment); no jump to address 0 is possible.
  - Halt_op=1 -> Done=1, Branch=0, next HALT.
  - Overrun: prog_ctr = all-ones with no taken branch and no halt -> Done=1, Err set, next HALT (no wrap to 0).
  - Halt and branch same cycle: halt wins.
  - Cycles increments each RUN cycle, saturates at all-ones.
- HALT: Done=1, Start=0, Branch=0, Ack=1 for exactly one cycle; next IDLE.
- Req outside IDLE ignored (not queued).
- Target table: 2**LUT_AW registers of D bits, all reset to 0. Write on rising edge when Lut_we, in any state. Read is combinational; same-cycle read of the written index returns the old value.

## Timing
- Reset (async assert, any state): state=IDLE, Start=1, Done=1, Branch=0, Ack=0, Err=0, Cycles=0, table all 0, target=0. Reset mid-run aborts with no Ack.
- Req in cycle n (IDLE) -> RUN from n+1, prog_ctr=0 at n+1.
- Branch/target/Done valid in the same cycle as decoder inputs; counter acts at the next edge.
- Halt_op in RUN cycle n -> counter holds at n+1, Ack=1 in cycle n+1, IDLE (Start=1) in n+2.
- Minimum Req-to-Req spacing: 3 cycles.

## Structure
- Package pc_ctl_pkg: state enum (IDLE, RUN, HALT) and default width constants D, LUT_AW, CW.
- Sub-module branch_lut: target register file (one write port, one combinational read port, async active-low reset).
- Top holds FSM, Cycles counter, Err flag, output decode.

## Test plan
- Reset then Req pulse -> Start=1 until Req edge, prog_ctr 0 next cycle, Start=0, Cycles counting from 1.
- Write lut[3]=0x040; RUN with Br_op=1, Br_cond=1, Lut_idx=3 -> Branch=1, target=0x040; Br_cond=0 -> Branch=0.
- lut[5]=0 with taken branch on idx 5 -> Branch=0, counter increments.
- Halt_op and taken branch in same cycle -> Branch=0, Done=1, Ack one cycle later, Cycles stops at run length.
- Run with prog_ctr reaching 0xFFF and no branch -> Done=1, Err=1, Ack; next Req clears Err and Cycles.
- Reset_n asserted mid-RUN -> immediate IDLE outputs, table cleared, no Ack; Req during RUN/HALT ignored.

Source files
------------

// File: rtl/pc_ctl_pkg.sv
// Shared types and default widths for the program-counter run controller.
package pc_ctl_pkg;

   localparam int PC_D      = 12;  // program counter / target width
   localparam int PC_LUT_AW = 3;   // target-table index width
   localparam int PC_CW     = 16;  // run cycle counter width

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

endpackage

// File: rtl/pc_ctl_branch_lut.sv
// Branch target table: one synchronous write port, one combinational read port.
// A read of the index being written in the same cycle returns the old entry.
module branch_lut
   import pc_ctl_pkg::*;
#(
   parameter int D  = PC_D,
   parameter int AW = PC_LUT_AW
) (
   input  logic          clk,
   input  logic          Reset_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [D-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [D-1:0]  rdata_o
);

   logic [D-1:0] mem_q [2**AW];

   // Table storage; every entry clears to zero, which reads as "branch not taken".
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 2**AW; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_ctl.sv
// Run controller and branch-target generator for the program counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | counter pinned at 0 (Start, Done); waiting for Req
//   RUN     | counter free-running; branches resolved through the table
//   HALT    | counter held; one-cycle Ack, then back to IDLE
module pc_ctl
   import pc_ctl_pkg::*;
#(
   parameter int D      = PC_D,
   parameter int LUT_AW = PC_LUT_AW,
   parameter int CW     = PC_CW
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic              Req,
   output logic              Ack,
   output logic              Err,
   output logic [CW-1:0]     Cycles,
   input  logic [D-1:0]      prog_ctr,
   input  logic              Halt_op,
   input  logic              Br_op,
   input  logic              Br_cond,
   input  logic [LUT_AW-1:0] Lut_idx,
   input  logic              Lut_we,
   input  logic [LUT_AW-1:0] Lut_waddr,
   input  logic [D-1:0]      Lut_wdata,
   output logic              Start,
   output logic              Done,
   output logic              Branch,
   output logic [D-1:0]      target
);

   state_e        state_q, state_d;
   logic [CW-1:0] cycles_q, cycles_d;
   logic          err_q, err_d;
   logic [D-1:0]  lut_rd;
   logic          taken;
   logic          overrun;

   branch_lut #(
      .D  (D),
      .AW (LUT_AW)
   ) u_lut (
      .clk     (clk),
      .Reset_n (Reset_n),
      .we_i    (Lut_we),
      .waddr_i (Lut_waddr),
      .wdata_i (Lut_wdata),
      .raddr_i (Lut_idx),
      .rdata_o (lut_rd)
   );

   // A zero entry is "not taken": the counter cannot jump to address 0.
   assign taken   = Br_op & Br_cond & (lut_rd != '0) & ~Halt_op;
   // Stop rather than let the counter wrap back to 0.
   assign overrun = (prog_ctr == '1) & ~taken & ~Halt_op;

   assign target = lut_rd;
   assign Err    = err_q;
   assign Cycles = cycles_q;

   // State, run-length counter and sticky overrun flag.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= ST_IDLE;
         cycles_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cycles_q <= cycles_d;
         err_q    <= err_d;
      end
   end

   // Next-state and counter control decode; halt has priority over branch and overrun.
   always_comb begin
      state_d  = state_q;
      cycles_d = cycles_q;
      err_d    = err_q;
      Start    = 1'b0;
      Done     = 1'b0;
      Branch   = 1'b0;
      Ack      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            Start = 1'b1;
            Done  = 1'b1;
            if (Req) begin
               state_d  = ST_RUN;
               cycles_d = '0;
               err_d    = 1'b0;
            end
         end
         ST_RUN: begin
            if (cycles_q != '1) begin
               cycles_d = cycles_q + CW'(1);
            end
            if (Halt_op) begin
               Done    = 1'b1;
               state_d = ST_HALT;
            end else if (overrun) begin
               Done    = 1'b1;
               err_d   = 1'b1;
               state_d = ST_HALT;
            end else begin
               Branch = taken;
            end
         end
         ST_HALT: begin
            Done    = 1'b1;
            Ack     = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_ctl.sv
// Self-checking bench for pc_ctl: directed vector table, reset sequence,
// then random stimulus against a behavioural model with a simple counter.
module tb_pc_ctl;

   localparam int D    = 12;
   localparam int AW   = 3;
   localparam int CW   = 16;
   localparam int PMAX = (1 << D) - 1;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          Req = 1'b0;
   logic          Ack;
   logic          Err;
   logic [CW-1:0] Cycles;
   logic [D-1:0]  prog_ctr = '0;
   logic          Halt_op = 1'b0;
   logic          Br_op = 1'b0;
   logic          Br_cond = 1'b0;
   logic [AW-1:0] Lut_idx = '0;
   logic          Lut_we = 1'b0;
   logic [AW-1:0] Lut_waddr = '0;
   logic [D-1:0]  Lut_wdata = '0;
   logic          Start;
   logic          Done;
   logic          Branch;
   logic [D-1:0]  target;

   always #5 clk = ~clk;

   pc_ctl #(.D(D), .LUT_AW(AW), .CW(CW)) dut (
      .clk       (clk),
      .Reset_n   (Reset_n),
      .Req       (Req),
      .Ack       (Ack),
      .Err       (Err),
      .Cycles    (Cycles),
      .prog_ctr  (prog_ctr),
      .Halt_op   (Halt_op),
      .Br_op     (Br_op),
      .Br_cond   (Br_cond),
      .Lut_idx   (Lut_idx),
      .Lut_we    (Lut_we),
      .Lut_waddr (Lut_waddr),
      .Lut_wdata (Lut_wdata),
      .Start     (Start),
      .Done      (Done),
      .Branch    (Branch),
      .target    (target)
   );

   typedef struct {
      bit req, halt, bop, bc;
      int idx;
      bit we;
      int wa, wd;
      bit s, d, b, a, e;
      int cyc, tgt;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Behavioural model: run/ack flags, table contents, counters, and the program counter.
   int m_lut[1 << AW];
   bit m_run, m_ack, m_err;
   int m_cyc;
   int pc;
   bit e_s, e_d, e_b, e_a;
   int e_tgt;

   function automatic void chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < (1 << AW); i++) m_lut[i] = 0;
      m_run = 0; m_ack = 0; m_err = 0; m_cyc = 0; pc = 0;
   endfunction

   function automatic bit br_taken(bit bop, bit bc, int idx);
      return bop && bc && (m_lut[idx] != 0);
   endfunction

   function automatic void model_outs(bit halt, bit bop, bit bc, int idx);
      e_tgt = m_lut[idx];
      e_s = 0; e_d = 0; e_b = 0; e_a = 0;
      if (m_run) begin
         if (halt)                         e_d = 1;
         else if (br_taken(bop, bc, idx))  e_b = 1;
         else if (pc == PMAX)              e_d = 1;
      end else if (m_ack) begin
         e_d = 1; e_a = 1;
      end else begin
         e_s = 1; e_d = 1;
      end
   endfunction

   function automatic void model_edge(vec_t v);
      int nxt;
      nxt = e_s ? 0 : e_d ? pc : e_b ? e_tgt : ((pc + 1) & PMAX);
      if (m_run) begin
         if (m_cyc < CMAX) m_cyc++;
         if (v.halt) begin
            m_run = 0; m_ack = 1;
         end else if (pc == PMAX && !br_taken(v.bop, v.bc, v.idx)) begin
            m_run = 0; m_ack = 1; m_err = 1;
         end
      end else if (m_ack) begin
         m_ack = 0;
      end else if (v.req) begin
         m_run = 1; m_cyc = 0; m_err = 0;
      end
      if (v.we) m_lut[v.wa] = v.wd;
      pc = nxt;
   endfunction

   function automatic vec_t mk(bit req, bit halt, bit bop, bit bc, int idx,
                               bit we, int wa, int wd,
                               bit s, bit d, bit b, bit a, bit e, int cyc, int tgt);
      vec_t v;
      v.req = req; v.halt = halt; v.bop = bop; v.bc = bc; v.idx = idx;
      v.we = we; v.wa = wa; v.wd = wd;
      v.s = s; v.d = d; v.b = b; v.a = a; v.e = e; v.cyc = cyc; v.tgt = tgt;
      return v;
   endfunction

   task automatic step(vec_t v, bit from_tbl);
      @(posedge clk); #1;
      Req       = v.req;
      Halt_op   = v.halt;
      Br_op     = v.bop;
      Br_cond   = v.bc;
      Lut_idx   = AW'(v.idx);
      Lut_we    = v.we;
      Lut_waddr = AW'(v.wa);
      Lut_wdata = D'(v.wd);
      prog_ctr  = D'(pc);
      @(negedge clk);
      model_outs(v.halt, v.bop, v.bc, v.idx);
      if (from_tbl) begin
         chk("tbl_start",  int'(Start),  int'(v.s));
         chk("tbl_done",   int'(Done),   int'(v.d));
         chk("tbl_branch", int'(Branch), int'(v.b));
         chk("tbl_ack",    int'(Ack),    int'(v.a));
         chk("tbl_err",    int'(Err),    int'(v.e));
         chk("tbl_cycles", int'(Cycles), v.cyc);
         chk("tbl_target", int'(target), v.tgt);
      end else begin
         chk("mdl_start",  int'(Start),  int'(e_s));
         chk("mdl_done",   int'(Done),   int'(e_d));
         chk("mdl_branch", int'(Branch), int'(e_b));
         chk("mdl_ack",    int'(Ack),    int'(e_a));
         chk("mdl_err",    int'(Err),    int'(m_err));
         chk("mdl_cycles", int'(Cycles), m_cyc);
         chk("mdl_target", int'(target), e_tgt);
      end
      model_edge(v);
   endtask

   initial begin
      vec_t v;
      model_reset();

      // Directed trace: table writes, launch, branch taken/not, zero entry, halt+branch,
      // overrun at 0xFFF, Err/Cycles clear on the next Req.
      //            req h bo bc idx we wa wd      s d b a e cyc tgt
      tbl.push_back(mk(0,0,0,0, 3, 1,3,'h040,   1,1,0,0,0, 0,'h000));
      tbl.push_back(mk(0,0,0,0, 3, 1,6,'hFF0,   1,1,0,0,0, 0,'h040));
      tbl.push_back(mk(1,0,0,0, 6, 0,0,0,       1,1,0,0,0, 0,'hFF0));
      tbl.push_back(mk(0,0,1,1, 3, 0,0,0,       0,0,1,0,0, 0,'h040));
      tbl.push_back(mk(0,0,1,0, 3, 0,0,0,       0,0,0,0,0, 1,'h040));
      tbl.push_back(mk(0,0,1,1, 5, 0,0,0,       0,0,0,0,0, 2,'h000));
      tbl.push_back(mk(1,0,0,0, 0, 0,0,0,       0,0,0,0,0, 3,'h000));
      tbl.push_back(mk(0,1,1,1, 3, 0,0,0,       0,1,0,0,0, 4,'h040));
      tbl.push_back(mk(1,0,0,0, 0, 0,0,0,       0,1,0,1,0, 5,'h000));
      tbl.push_back(mk(0,0,0,0, 0, 0,0,0,       1,1,0,0,0, 5,'h000));
      tbl.push_back(mk(1,0,0,0, 0, 0,0,0,       1,1,0,0,0, 5,'h000));
      tbl.push_back(mk(0,0,1,1, 6, 0,0,0,       0,0,1,0,0, 0,'hFF0));
      for (int k = 1; k <= 15; k++)
         tbl.push_back(mk(0,0,0,0, 0, 0,0,0,    0,0,0,0,0, k,'h000));
      tbl.push_back(mk(0,0,0,0, 0, 0,0,0,       0,1,0,0,0,16,'h000));
      tbl.push_back(mk(0,0,0,0, 0, 0,0,0,       0,1,0,1,1,17,'h000));
      tbl.push_back(mk(1,0,0,0, 0, 0,0,0,       1,1,0,0,1,17,'h000));
      tbl.push_back(mk(0,1,0,0, 0, 0,0,0,       0,1,0,0,0, 0,'h000));
      tbl.push_back(mk(0,0,0,0, 0, 0,0,0,       0,1,0,1,0, 1,'h000));
      tbl.push_back(mk(0,0,0,0, 3, 0,0,0,       1,1,0,0,0, 1,'h040));

      // Reset state.
      #2;
      chk("rst_start",  int'(Start),  1);
      chk("rst_done",   int'(Done),   1);
      chk("rst_branch", int'(Branch), 0);
      chk("rst_ack",    int'(Ack),    0);
      chk("rst_err",    int'(Err),    0);
      chk("rst_cycles", int'(Cycles), 0);
      chk("rst_target", int'(target), 0);
      #10 Reset_n = 1'b1;

      foreach (tbl[i]) step(tbl[i], 1'b1);

      // Reset asserted mid-run: outputs go to IDLE values at once, table cleared, no Ack.
      step(mk(1,0,0,0, 3, 0,0,0, 0,0,0,0,0, 0,0), 1'b0);
      step(mk(0,0,1,1, 3, 0,0,0, 0,0,0,0,0, 0,0), 1'b0);
      step(mk(0,0,0,0, 3, 0,0,0, 0,0,0,0,0, 0,0), 1'b0);
      @(posedge clk); #3;
      Halt_op = 1'b0; Br_op = 1'b1; Br_cond = 1'b1; Lut_idx = AW'(3);
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_start",  int'(Start),  1);
      chk("mid_rst_done",   int'(Done),   1);
      chk("mid_rst_branch", int'(Branch), 0);
      chk("mid_rst_ack",    int'(Ack),    0);
      chk("mid_rst_cycles", int'(Cycles), 0);
      chk("mid_rst_target", int'(target), 0);
      model_reset();
      #3 Reset_n = 1'b1;
      step(mk(0,0,1,1, 3, 0,0,0, 0,0,0,0,0, 0,0), 1'b0);
      step(mk(0,0,0,0, 3, 0,0,0, 0,0,0,0,0, 0,0), 1'b0);

      // Randomized stimulus against the model.
      for (int n = 0; n < 4000; n++) begin
         v = mk(($urandom_range(3) == 0), ($urandom_range(15) == 0),
                $urandom_range(1), $urandom_range(1), $urandom_range((1 << AW) - 1),
                ($urandom_range(5) == 0), $urandom_range((1 << AW) - 1),
                ($urandom_range(3) == 0) ? 0 :
                ($urandom_range(1) ? $urandom_range(PMAX, PMAX - 40) : $urandom_range(PMAX, 1)),
                0,0,0,0,0, 0,0);
         step(v, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
